rbz_tex_flash_arb: RTL and testbench
====================================

Name: rbz_tex_flash_arb

Overview:
- Shares the single texture SPI flash between two requesters: 0 = row renderer texel fetch, 1 = texture prefetch/preload.
- Arbitrates round-robin between them, then sequences one SPI-mode-0 dual-output read (0x3B) per grant.
- Returns NBYTES of data to the granted requester with a one-cycle ack.
- Sits between the raycaster texture path and the uio tex pins (csb, sclk, io0 bidirectional, io1 input).

Parameters:
- NBYTES, 1, data bytes read per transaction (legal 1..4).
- DUMMY_CLKS, 8, SCLK cycles between the last address bit and the first data bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  2  per-requester level request; must be held until the matching o_ack.
- i_addr0  in  24  flash byte address for requester 0.
- i_addr1  in  24  flash byte address for requester 1.
- o_ack  out  2  one-hot, one-cycle pulse: o_data is valid for that requester.
- o_data  out  8*NBYTES  read data; holds its value until the next ack.
- o_busy  out  1  high when state is not IDLE.
- o_tex_csb  out  1  flash chip select, active low.
- o_tex_sclk  out  1  flash clock, clk/2, idles low.
- o_tex_out0  out  1  io0 output data (MOSI).
- o_tex_oeb0  out  1  io0 output enable, active LOW (1 = released).
- i_tex_in  in  2  {io1, io0} flash data inputs.

Behaviour:
- Reset (async, takes effect immediately, including mid-transaction) forces:
  - state = IDLE, o_tex_csb = 1, o_tex_sclk = 0, o_tex_out0 = 0, o_tex_oeb0 = 1;
  - o_ack = 0, o_data = 0, o_busy = 0;
  - round-robin pointer = "requester 0 preferred".
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> DONE -> IDLE.
- IDLE, cycle t, with any i_req bit set:
  - grant one requester, latch its address, next state CMD;
  - o_tex_csb goes low at t+1.
  - Addresses are sampled only at grant; later changes are ignored.
- Arbitration:
  - only one requester pending: grant it;
  - both pending: grant the one not granted last; pointer updates at grant.
  - After reset, a simultaneous request serves 0 first.
- SPI bit timing, 2 clk per SCLK period:
  - phase L: sclk = 0, o_tex_out0 updates;
  - phase H: sclk = 1; i_tex_in is registered on the clk edge that drives sclk 1 -> 0 (end of phase H).
- CMD: 8 bits of 0x3B, MSB first, on io0; o_tex_oeb0 = 0.
- ADDR: 24 address bits, MSB first; o_tex_oeb0 = 0 through the last address phase H.
- DUMMY: DUMMY_CLKS SCLK periods; o_tex_oeb0 = 1 from the first dummy phase L; o_tex_out0 = 0.
- DATA: 4*NBYTES SCLK periods.
  - Each period shifts in 2 bits, i_tex_in[1] being the more significant.
  - The first received byte lands in o_data[8*NBYTES-1 -: 8] (big-endian).
- DONE, one cycle:
  - o_tex_csb = 1, o_tex_sclk = 0;
  - o_data updated, o_ack[granted] = 1.
  - Next state IDLE. CS-high is therefore ≥ 2 clk between transactions.
- Latency: grant at cycle t gives o_ack high in cycle t + 2*(8+24+DUMMY_CLKS+4*NBYTES) + 1. Default = t+89.
- A request dropped mid-transaction is a protocol violation: the transaction still completes and acks the granted id.
- An ack'd requester that keeps i_req high is treated as a new request in the following IDLE cycle.
- Counters:
  - a single 6-bit bit counter, reloaded on every state entry;
  - a 1-bit phase toggle.
- No combinational path from i_req/i_addr* to any pin output; all outputs are registered.

Decomposition:
- Package rbz_tex_flash_pkg:
  - state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE);
  - CMD_DUAL_READ = 8'h3B;
  - CMD_BITS = 8, ADDR_BITS = 24.
- One sub-module, rbz_rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], a grant strobe.
  - Outputs: one-hot gnt and the last-granted pointer.
- The SPI sequencer stays in the top FSM.

Test Plan:
1. Request 0, addr 0x123456; flash model returns 0xA5.
   - io0 sampled on sclk rises reads 0x3B,0x12,0x34,0x56.
   - o_tex_oeb0 = 0 for 32 SCLKs, then 1.
   - o_ack = 2'b01 exactly at t+89, o_data = 0xA5.
2. Both requests asserted in the same cycle after reset, addrs 0x000010 / 0x000020.
   - Req0 is served first, req1 second.
   - o_tex_csb high for ≥ 2 clk between the two transactions.
3. Both held continuously for 4 transactions: grant order 0,1,0,1; each ack is one cycle.
4. Reset asserted during ADDR bit 10:
   - o_tex_csb = 1, o_tex_sclk = 0, o_tex_oeb0 = 1 in the same cycle; o_busy = 0.
   - A subsequent request completes correctly with the full 0x3B header.
5. NBYTES = 2; flash returns 0xDE then 0xAD: o_data = 0xDEAD, ack at t+97.
6. Only req1, with i_addr1 changed one cycle after grant: the latched address is sent. Ack = 2'b10.

Source files
------------

// File: rtl/rbz_tex_flash_pkg.sv
// rtl/rbz_tex_flash_pkg.sv - shared types and constants for the texture flash arbiter
package rbz_tex_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [7:0] CMD_DUAL_READ = 8'h3B;
    localparam int         CMD_BITS      = 8;
    localparam int         ADDR_BITS     = 24;

    // Bit counter counts down to zero, so a phase of n SCLKs loads n-1.
    function automatic logic [5:0] cnt_load(input int n);
        return 6'(n - 1);
    endfunction

endpackage

// File: rtl/rbz_tex_flash_arb_if.sv
// rtl/rbz_tex_flash_arb_if.sv - requester and flash pin bundle for the texture flash arbiter
interface rbz_tex_flash_arb_if #(
    parameter int NBYTES = 1
);
    logic [1:0]          i_req;
    logic [23:0]         i_addr0;
    logic [23:0]         i_addr1;
    logic [1:0]          o_ack;
    logic [8*NBYTES-1:0] o_data;
    logic                o_busy;
    logic                o_tex_csb;
    logic                o_tex_sclk;
    logic                o_tex_out0;
    logic                o_tex_oeb0;
    logic [1:0]          i_tex_in;

    modport slave (
        input  i_req, i_addr0, i_addr1, i_tex_in,
        output o_ack, o_data, o_busy, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0
    );

    modport master (
        output i_req, i_addr0, i_addr1, i_tex_in,
        input  o_ack, o_data, o_busy, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0
    );
endinterface

// File: rtl/rbz_rr_arb2.sv
// rtl/rbz_rr_arb2.sv - two-way round-robin arbiter with last-granted pointer
module rbz_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       gnt_stb_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q, last_d;

    // last_q resets to 1 so that a simultaneous first request favours requester 0.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt_stb_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/rbz_tex_flash_arb.sv
// rtl/rbz_tex_flash_arb.sv - round-robin sharing of the texture SPI flash with dual-output 0x3B reads
module rbz_tex_flash_arb
    import rbz_tex_flash_pkg::*;
#(
    parameter int NBYTES     = 1,
    parameter int DUMMY_CLKS = 8
) (
    input  logic               clk,
    input  logic               reset,
    rbz_tex_flash_arb_if.slave bus
);

    localparam int DW        = 8 * NBYTES;
    localparam int DATA_CLKS = 4 * NBYTES;

    state_e          state_q, state_d;
    logic            phase_q, phase_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [23:0]     addr_q, addr_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            csb_q, csb_d;
    logic            sclk_q, sclk_d;
    logic            out0_q, out0_d;
    logic            oeb0_q, oeb0_d;
    logic            spi_d;

    logic [1:0]      gnt;
    logic            gnt_stb;
    logic            last_gnt;

    assign gnt_stb = (state_q == ST_IDLE);

    rbz_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .req_i     (bus.i_req),
        .gnt_stb_i (gnt_stb),
        .gnt_o     (gnt),
        .last_o    (last_gnt)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req != 2'b00) begin
                    state_d = ST_CMD;
                    phase_d = 1'b0;
                    cnt_d   = cnt_load(CMD_BITS);
                    addr_d  = ({24{gnt[0]}} & bus.i_addr0) | ({24{gnt[1]}} & bus.i_addr1);
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                phase_d = ~phase_q;
                // Everything advances on the edge that ends phase H (sclk 1 -> 0).
                if (phase_q) begin
                    if (state_q == ST_DATA) begin
                        shift_d = {shift_q[DW-3:0], bus.i_tex_in};
                    end
                    if (cnt_q == 6'd0) begin
                        case (state_q)
                            ST_CMD: begin
                                state_d = ST_ADDR;
                                cnt_d   = cnt_load(ADDR_BITS);
                            end
                            ST_ADDR: begin
                                state_d = ST_DUMMY;
                                cnt_d   = cnt_load(DUMMY_CLKS);
                            end
                            ST_DUMMY: begin
                                state_d = ST_DATA;
                                cnt_d   = cnt_load(DATA_CLKS);
                            end
                            default: begin
                                state_d = ST_DONE;
                                cnt_d   = 6'd0;
                                data_d  = shift_d;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
                cnt_d   = 6'd0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Pin outputs are decoded from next-state so every pin comes straight off a flop.
    always_comb begin
        spi_d  = (state_d == ST_CMD) || (state_d == ST_ADDR) ||
                 (state_d == ST_DUMMY) || (state_d == ST_DATA);
        csb_d  = ~spi_d;
        sclk_d = spi_d & phase_d;
        oeb0_d = ~((state_d == ST_CMD) || (state_d == ST_ADDR));
        out0_d = 1'b0;
        case (state_d)
            ST_CMD:  out0_d = CMD_DUAL_READ[cnt_d[2:0]];
            ST_ADDR: out0_d = addr_d[cnt_d[4:0]];
            default: out0_d = 1'b0;
        endcase
        ack_d  = (state_d == ST_DONE) ? {last_gnt, ~last_gnt} : 2'b00;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= 6'd0;
            addr_q  <= 24'd0;
            shift_q <= '0;
            data_q  <= '0;
            ack_q   <= 2'b00;
            busy_q  <= 1'b0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            out0_q  <= 1'b0;
            oeb0_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            out0_q  <= out0_d;
            oeb0_q  <= oeb0_d;
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_data     = data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_tex_csb  = csb_q;
    assign bus.o_tex_sclk = sclk_q;
    assign bus.o_tex_out0 = out0_q;
    assign bus.o_tex_oeb0 = oeb0_q;

endmodule

// File: tb/tb_rbz_tex_flash_arb.sv
// tb/tb_rbz_tex_flash_arb.sv - directed self-checking bench for rbz_tex_flash_arb
module tb_rbz_tex_flash_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rbz_tex_flash_arb_if #(.NBYTES(1)) if1 ();
    rbz_tex_flash_arb_if #(.NBYTES(2)) if2 ();

    rbz_tex_flash_arb #(.NBYTES(1), .DUMMY_CLKS(8)) dut1 (.clk(clk), .reset(rst), .bus(if1));
    rbz_tex_flash_arb #(.NBYTES(2), .DUMMY_CLKS(8)) dut2 (.clk(clk), .reset(rst), .bus(if2));

    logic [31:0] flash1 = 32'd0;
    logic [31:0] flash2 = 32'd0;
    logic [1:0]  tex1 = 2'b00;
    logic [1:0]  tex2 = 2'b00;
    int          rises1 = 0, rises2 = 0, t_rises1 = 0, oeb_err = 0, t_oeb_err = 0;
    logic [31:0] hdr = 32'd0, t_hdr = 32'd0;

    assign if1.i_tex_in = tex1;
    assign if2.i_tex_in = tex2;

    // Flash model 1: captures header on sclk rises, snapshots per-transaction results at CS rise.
    always @(posedge if1.o_tex_sclk or posedge if1.o_tex_csb) begin
        if (if1.o_tex_csb) begin
            t_rises1  = rises1;
            t_oeb_err = oeb_err;
            t_hdr     = hdr;
            rises1    = 0;
            oeb_err   = 0;
        end else begin
            if (rises1 < 32) begin
                hdr = {hdr[30:0], if1.o_tex_out0};
                if (if1.o_tex_oeb0 !== 1'b0) oeb_err++;
            end else if (if1.o_tex_oeb0 !== 1'b1) begin
                oeb_err++;
            end
            rises1++;
        end
    end

    always @(negedge if1.o_tex_sclk) begin
        int pr;
        #1;
        pr = rises1 - 40;
        if (pr >= 0 && pr < 4) tex1 = flash1[31-2*pr -: 2];
    end

    always @(posedge if2.o_tex_sclk or posedge if2.o_tex_csb) begin
        if (if2.o_tex_csb) rises2 = 0;
        else               rises2++;
    end

    always @(negedge if2.o_tex_sclk) begin
        int pr;
        #1;
        pr = rises2 - 40;
        if (pr >= 0 && pr < 8) tex2 = flash2[31-2*pr -: 2];
    end

    task automatic wait_ack1(input int start, output int cyc, output logic [1:0] ack);
        cyc = start;
        ack = 2'b00;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (if1.o_ack !== 2'b00) begin
                ack = if1.o_ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (if1.o_tex_csb !== 1'b1)  begin n_err++; $display("FAIL reset_csb got %b want 1", if1.o_tex_csb); end
        n_cmp++; if (if1.o_tex_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk got %b want 0", if1.o_tex_sclk); end
        n_cmp++; if (if1.o_tex_out0 !== 1'b0) begin n_err++; $display("FAIL reset_out0 got %b want 0", if1.o_tex_out0); end
        n_cmp++; if (if1.o_tex_oeb0 !== 1'b1) begin n_err++; $display("FAIL reset_oeb0 got %b want 1", if1.o_tex_oeb0); end
        n_cmp++; if (if1.o_ack !== 2'b00)     begin n_err++; $display("FAIL reset_ack got %b want 00", if1.o_ack); end
        n_cmp++; if (if1.o_data !== 8'h00)    begin n_err++; $display("FAIL reset_data got %h want 00", if1.o_data); end
        n_cmp++; if (if1.o_busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", if1.o_busy); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_req0();
        int cyc; logic [1:0] ack;
        @(negedge clk);
        flash1 = 32'hA500_0000;
        if1.i_addr0 = 24'h123456;
        if1.i_req = 2'b01;
        wait_ack1(0, cyc, ack);
        if1.i_req = 2'b00;
        n_cmp++; if (cyc != 89)               begin n_err++; $display("FAIL t1_latency got %0d want 89", cyc); end
        n_cmp++; if (ack !== 2'b01)           begin n_err++; $display("FAIL t1_ack got %b want 01", ack); end
        n_cmp++; if (if1.o_data !== 8'hA5)    begin n_err++; $display("FAIL t1_data got %h want a5", if1.o_data); end
        n_cmp++; if (t_hdr !== 32'h3B123456)  begin n_err++; $display("FAIL t1_header got %h want 3b123456", t_hdr); end
        n_cmp++; if (t_oeb_err != 0)          begin n_err++; $display("FAIL t1_oeb got %0d bad sclks want 0", t_oeb_err); end
        n_cmp++; if (t_rises1 != 44)          begin n_err++; $display("FAIL t1_sclks got %0d want 44", t_rises1); end
        n_cmp++; if (if1.o_busy !== 1'b1)     begin n_err++; $display("FAIL t1_busy_done got %b want 1", if1.o_busy); end
        @(posedge clk); #1;
        n_cmp++; if (if1.o_ack !== 2'b00)     begin n_err++; $display("FAIL t1_ack_width got %b want 00", if1.o_ack); end
        n_cmp++; if (if1.o_busy !== 1'b0)     begin n_err++; $display("FAIL t1_busy_idle got %b want 0", if1.o_busy); end
    endtask

    task automatic test_simultaneous();
        int cyc, hi; logic [1:0] ack;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        flash1 = 32'h3C00_0000;
        if1.i_addr0 = 24'h000010;
        if1.i_addr1 = 24'h000020;
        if1.i_req = 2'b11;
        wait_ack1(0, cyc, ack);
        if1.i_req = 2'b10;
        n_cmp++; if (ack !== 2'b01)           begin n_err++; $display("FAIL t2_first_ack got %b want 01", ack); end
        n_cmp++; if (t_hdr !== 32'h3B000010)  begin n_err++; $display("FAIL t2_first_header got %h want 3b000010", t_hdr); end
        n_cmp++; if (if1.o_data !== 8'h3C)    begin n_err++; $display("FAIL t2_first_data got %h want 3c", if1.o_data); end
        hi = (if1.o_tex_csb === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (if1.o_tex_csb === 1'b1) hi++;
            else break;
        end
        n_cmp++; if (hi < 2)                  begin n_err++; $display("FAIL t2_csb_gap got %0d clk want >=2", hi); end
        wait_ack1(1, cyc, ack);
        if1.i_req = 2'b00;
        n_cmp++; if (ack !== 2'b10)           begin n_err++; $display("FAIL t2_second_ack got %b want 10", ack); end
        n_cmp++; if (cyc != 89)               begin n_err++; $display("FAIL t2_second_latency got %0d want 89", cyc); end
        n_cmp++; if (t_hdr !== 32'h3B000020)  begin n_err++; $display("FAIL t2_second_header got %h want 3b000020", t_hdr); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc; logic [1:0] ack;
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        flash1 = 32'h5A00_0000;
        if1.i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack1(0, cyc, ack);
            n_cmp++; if (ack !== want[k])     begin n_err++; $display("FAIL t3_order[%0d] got %b want %b", k, ack, want[k]); end
            n_cmp++; if (cyc != 89)           begin n_err++; $display("FAIL t3_latency[%0d] got %0d want 89", k, cyc); end
            if (k == 3) if1.i_req = 2'b00;
            @(posedge clk); #1;
            n_cmp++; if (if1.o_ack !== 2'b00) begin n_err++; $display("FAIL t3_ack_width[%0d] got %b want 00", k, if1.o_ack); end
        end
    endtask

    task automatic test_reset_mid_addr();
        int cyc; logic [1:0] ack;
        @(negedge clk);
        if1.i_addr0 = 24'hFFFFFF;
        if1.i_req = 2'b01;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rises1 >= 19) break;
        end
        n_cmp++; if (if1.o_tex_csb !== 1'b0)  begin n_err++; $display("FAIL t4_in_addr_csb got %b want 0", if1.o_tex_csb); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (if1.o_tex_csb !== 1'b1)  begin n_err++; $display("FAIL t4_csb got %b want 1", if1.o_tex_csb); end
        n_cmp++; if (if1.o_tex_sclk !== 1'b0) begin n_err++; $display("FAIL t4_sclk got %b want 0", if1.o_tex_sclk); end
        n_cmp++; if (if1.o_tex_oeb0 !== 1'b1) begin n_err++; $display("FAIL t4_oeb0 got %b want 1", if1.o_tex_oeb0); end
        n_cmp++; if (if1.o_busy !== 1'b0)     begin n_err++; $display("FAIL t4_busy got %b want 0", if1.o_busy); end
        if1.i_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        flash1 = 32'hC300_0000;
        if1.i_addr0 = 24'h00ABCD;
        if1.i_req = 2'b01;
        wait_ack1(0, cyc, ack);
        if1.i_req = 2'b00;
        n_cmp++; if (ack !== 2'b01)           begin n_err++; $display("FAIL t4_ack got %b want 01", ack); end
        n_cmp++; if (cyc != 89)               begin n_err++; $display("FAIL t4_latency got %0d want 89", cyc); end
        n_cmp++; if (t_hdr !== 32'h3B00ABCD)  begin n_err++; $display("FAIL t4_header got %h want 3b00abcd", t_hdr); end
        n_cmp++; if (if1.o_data !== 8'hC3)    begin n_err++; $display("FAIL t4_data got %h want c3", if1.o_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_two_bytes();
        int cyc; logic [1:0] ack;
        @(negedge clk);
        flash2 = 32'hDEAD_0000;
        if2.i_addr0 = 24'h000100;
        if2.i_req = 2'b01;
        cyc = 0;
        ack = 2'b00;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (if2.o_ack !== 2'b00) begin ack = if2.o_ack; break; end
        end
        if2.i_req = 2'b00;
        n_cmp++; if (cyc != 97)               begin n_err++; $display("FAIL t5_latency got %0d want 97", cyc); end
        n_cmp++; if (ack !== 2'b01)           begin n_err++; $display("FAIL t5_ack got %b want 01", ack); end
        n_cmp++; if (if2.o_data !== 16'hDEAD) begin n_err++; $display("FAIL t5_data got %h want dead", if2.o_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_latch_req1();
        int cyc; logic [1:0] ack;
        @(negedge clk);
        flash1 = 32'h6900_0000;
        if1.i_addr0 = 24'h000000;
        if1.i_addr1 = 24'hABCDEF;
        if1.i_req = 2'b10;
        @(posedge clk); #1;
        if1.i_addr1 = 24'h111111;
        wait_ack1(1, cyc, ack);
        if1.i_req = 2'b00;
        n_cmp++; if (ack !== 2'b10)           begin n_err++; $display("FAIL t6_ack got %b want 10", ack); end
        n_cmp++; if (cyc != 89)               begin n_err++; $display("FAIL t6_latency got %0d want 89", cyc); end
        n_cmp++; if (t_hdr !== 32'h3BABCDEF)  begin n_err++; $display("FAIL t6_header got %h want 3babcdef", t_hdr); end
        n_cmp++; if (if1.o_data !== 8'h69)    begin n_err++; $display("FAIL t6_data got %h want 69", if1.o_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        if1.i_req   = 2'b00;
        if1.i_addr0 = 24'd0;
        if1.i_addr1 = 24'd0;
        if2.i_req   = 2'b00;
        if2.i_addr0 = 24'd0;
        if2.i_addr1 = 24'd0;
        test_reset();
        test_single_req0();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_addr();
        test_two_bytes();
        test_addr_latch_req1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
